// File: rtl/exc_irq_ctrl.sv
// ---------------------------------------------------------------------------
// exc_irq_ctrl
//
// Interrupt / exception controller for the pipelined CPU. Collects
// synchronous exceptions from every pipeline stage plus level-sensitive
// external interrupt lines, selects one event by priority, flushes the
// affected stages, captures EPC and cause, redirects the PC to a per-cause
// handler vector and returns to the saved EPC on ERET.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   exc_valid      per-stage exception request (index NUM_STAGES-1 = oldest)
//   exc_code       per-stage 2-bit code: 01 illegal, 10 overflow, 11 syscall
//   exc_pc         per-stage instruction PC
//   commit_pc      EPC used for external interrupts
//   irq            external interrupt lines (level)
//   irq_mask       1 = line enabled
//   irq_ack        one-hot pulse clearing a pending line
//   eret           return-from-exception pulse
//   flush          per-stage synchronous reset
//   pc_load        PC register load enable
//   pc_redirect    select pc_target as next PC
//   pc_target      handler vector or EPC
//   epc, cause     saved PC and cause (100 = none)
//   irq_pending    latched interrupt lines
//   in_handler     handler currently running
//   nest_err       sticky: exception taken while in_handler
// ---------------------------------------------------------------------------
module exc_irq_ctrl #(
  parameter int          PC_WIDTH      = 32,
  parameter int          NUM_STAGES    = 5,
  parameter int          NUM_IRQ       = 4,
  parameter int          FLUSH_CYCLES  = 1,
  parameter int unsigned HANDLER_BASE  = 32'h0000_0080,
  parameter int unsigned VECTOR_STRIDE = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_STAGES-1:0]          exc_valid,
  input  logic [2*NUM_STAGES-1:0]        exc_code,
  input  logic [PC_WIDTH*NUM_STAGES-1:0] exc_pc,
  input  logic [PC_WIDTH-1:0]            commit_pc,
  input  logic [NUM_IRQ-1:0]             irq,
  input  logic [NUM_IRQ-1:0]             irq_mask,
  input  logic [NUM_IRQ-1:0]             irq_ack,
  input  logic                           eret,
  output logic [NUM_STAGES-1:0]          flush,
  output logic                           pc_load,
  output logic                           pc_redirect,
  output logic [PC_WIDTH-1:0]            pc_target,
  output logic [PC_WIDTH-1:0]            epc,
  output logic [2:0]                     cause,
  output logic [NUM_IRQ-1:0]             irq_pending,
  output logic                           in_handler,
  output logic                           nest_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_VECTOR,
    S_HANDLER,
    S_RETURN
  } state_t;

  localparam logic [2:0]          CAUSE_EXT  = 3'b000;
  localparam logic [2:0]          CAUSE_NONE = 3'b100;
  localparam logic [2:0]          FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] VEC_BASE   = PC_WIDTH'(HANDLER_BASE);
  localparam logic [PC_WIDTH-1:0] VEC_STRIDE = PC_WIDTH'(VECTOR_STRIDE);

  state_t               state;
  logic [2:0]           flush_cnt;
  logic [NUM_IRQ-1:0]   irq_prev;

  logic                  exc_hit;
  logic [1:0]            exc_sel_code;
  logic [PC_WIDTH-1:0]   exc_sel_pc;
  logic [NUM_STAGES-1:0] exc_sel_mask;
  logic                  irq_hit;
  logic                  take_exc;
  logic                  take_irq;
  logic [PC_WIDTH-1:0]   vector_addr;

  // Scan from the oldest stage down: the first hit wins, and every stage at
  // or below it (younger instructions) is marked for flushing.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    exc_hit      = 1'b0;
    exc_sel_code = 2'b00;
    exc_sel_pc   = '0;
    exc_sel_mask = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (exc_valid[s] && exc_code[2*s +: 2] != 2'b00) begin
        if (!exc_hit) begin
          exc_sel_code = exc_code[2*s +: 2];
          exc_sel_pc   = exc_pc[s*PC_WIDTH +: PC_WIDTH];
        end
        exc_hit = 1'b1;
      end
      exc_sel_mask[s] = exc_hit;
    end
  end

  assign irq_hit     = |(irq_pending & irq_mask);
  assign take_exc    = exc_hit && (state == S_IDLE || state == S_HANDLER);
  assign take_irq    = irq_hit && (state == S_IDLE);
  assign vector_addr = VEC_BASE + PC_WIDTH'(cause) * VEC_STRIDE;

  // Rising-edge detect on the interrupt lines; a new edge beats an ack.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev    <= '0;
      irq_pending <= '0;
    end else begin
      irq_prev    <= irq;
      irq_pending <= (irq_pending & ~irq_ack) | (irq & ~irq_prev);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      flush_cnt   <= '0;
      flush       <= '0;
      pc_load     <= 1'b1;
      pc_redirect <= 1'b0;
      pc_target   <= '0;
      epc         <= '0;
      cause       <= CAUSE_NONE;
      in_handler  <= 1'b0;
      nest_err    <= 1'b0;
    end else if (take_exc) begin
      // A synchronous exception also beats a simultaneous eret in HANDLER.
      if (state == S_HANDLER) nest_err <= 1'b1;
      cause     <= {1'b0, exc_sel_code};
      epc       <= exc_sel_pc;
      flush     <= exc_sel_mask;
      pc_load   <= 1'b0;
      flush_cnt <= FLUSH_INIT;
      state     <= S_FLUSH;
    end else if (take_irq) begin
      cause     <= CAUSE_EXT;
      epc       <= commit_pc;
      flush     <= '1;
      pc_load   <= 1'b0;
      flush_cnt <= FLUSH_INIT;
      state     <= S_FLUSH;
    end else begin
      case (state)
        S_FLUSH: begin
          if (flush_cnt == 3'd0) begin
            flush       <= '0;
            pc_load     <= 1'b1;
            pc_redirect <= 1'b1;
            pc_target   <= vector_addr;
            state       <= S_VECTOR;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        S_VECTOR: begin
          pc_redirect <= 1'b0;
          in_handler  <= 1'b1;
          state       <= S_HANDLER;
        end
        S_HANDLER: begin
          if (eret) begin
            pc_redirect <= 1'b1;
            pc_target   <= epc;
            flush       <= '1;
            cause       <= CAUSE_NONE;
            in_handler  <= 1'b0;
            state       <= S_RETURN;
          end
        end
        S_RETURN: begin
          pc_redirect <= 1'b0;
          flush       <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/exc_irq_ctrl.md
Name: exc_irq_ctrl

Overview:
- Parametrised interrupt/exception controller for the pipelined CPU.
- Collects synchronous exceptions from every pipeline stage and external interrupt lines, then picks one event by priority.
- Flushes the affected stages, captures EPC and cause, redirects the PC to a per-cause handler vector, and returns on ERET.
- Replaces the fixed "no interrupt" cause/flush logic of the stage-1 control.

Parameters:
- PC_WIDTH, 32, width of all PC values.
- NUM_STAGES, 5, number of pipeline stages; index NUM_STAGES-1 is the oldest stage.
- NUM_IRQ, 4, number of external interrupt lines.
- FLUSH_CYCLES, 1, number of cycles the flush is held (1..7).
- HANDLER_BASE, 32'h0000_0080, base address of the handler vectors.
- VECTOR_STRIDE, 16, byte distance between handler vectors; must be a power of two.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- exc_valid  in  NUM_STAGES  bit s=1: stage s reports a synchronous exception.
- exc_code  in  2*NUM_STAGES  per-stage code: 01 illegal instruction, 10 ALU overflow, 11 syscall, 00 = no exception.
- exc_pc  in  PC_WIDTH*NUM_STAGES  PC of the instruction in each stage.
- commit_pc  in  PC_WIDTH  PC of the next instruction to commit; used as EPC for external interrupts.
- irq  in  NUM_IRQ  external interrupt lines, level.
- irq_mask  in  NUM_IRQ  1 = line enabled.
- irq_ack  in  NUM_IRQ  one-hot pulse that clears a pending line.
- eret  in  1  return-from-exception, single-cycle pulse.
- flush  out  NUM_STAGES  per-stage synchronous reset.
- pc_load  out  1  load enable for the PC register.
- pc_redirect  out  1  select pc_target as the next PC.
- pc_target  out  PC_WIDTH  handler vector address or EPC.
- epc  out  PC_WIDTH  saved PC.
- cause  out  3  000 external, 001 illegal, 010 overflow, 011 syscall, 100 none.
- irq_pending  out  NUM_IRQ  latched pending interrupts.
- in_handler  out  1  high while the handler is running.
- nest_err  out  1  sticky: synchronous exception taken while in_handler.

Behaviour:
- Reset (async, reset_n=0) values:
  - flush=0, pc_load=1, pc_redirect=0, pc_target=0, epc=0.
  - cause=3'b100, irq_pending=0, in_handler=0, nest_err=0.
  - FSM goes to IDLE.
  - Mid-flush reset aborts the flush immediately.
- Pending register:
  - irq_pending[i] sets on a rising edge of irq[i], registered (previous-value compare).
  - It clears on irq_ack[i]. If a set and an ack occur in the same cycle, set wins.
- Event selection, evaluated combinationally in IDLE and HANDLER:
  - A synchronous exception beats an external interrupt.
  - Among stages, the highest index s with exc_valid[s]=1 and exc_code≠00 wins; exc_valid with code 00 is ignored.
  - An external interrupt is eligible only in IDLE, when |(irq_pending & irq_mask)=1.
- FSM states:
  - IDLE: on a selected event, in the same edge:
    - latch cause (code, or 000 for external);
    - latch epc (exc_pc[s], or commit_pc for external);
    - go to FLUSH with the counter at FLUSH_CYCLES-1.
  - FLUSH:
    - Synchronous event: flush[k]=1 for all k≤s.
    - External event: flush = all ones.
    - pc_load=0.
    - The counter decrements each cycle; at 0, go to VECTOR.
    - Events arriving during FLUSH are ignored.
  - VECTOR, one cycle:
    - pc_load=1, pc_redirect=1.
    - pc_target = HANDLER_BASE + cause*VECTOR_STRIDE (width PC_WIDTH, wraps modulo 2^PC_WIDTH).
    - Go to HANDLER; in_handler=1 from the next cycle.
  - HANDLER:
    - External interrupts are not accepted; the pending bits keep latching.
    - A synchronous exception sets nest_err, overwrites cause/epc and re-enters FLUSH.
    - eret (with no simultaneous exception) goes to RETURN. If eret and an exception arrive together, the exception wins.
  - RETURN, one cycle:
    - pc_load=1, pc_redirect=1, pc_target=epc, flush=all ones.
    - cause=100, in_handler=0, then IDLE.
    - eret in IDLE is ignored.
- Latency:
  - Event to first flush cycle: 1 clock.
  - Event to redirect: FLUSH_CYCLES+1 clocks.
- Outside FLUSH: pc_load=1 and flush=0, except in RETURN.

Test Plan:
- Reset: reset_n low mid-FLUSH → all outputs at their reset values asynchronously; cause=100 after release.
- Overflow: exc_valid=5'b01000, code of stage 3=10, pc=0x40, FLUSH_CYCLES=1 → next cycle flush=5'b01111 and pc_load=0; following cycle pc_target=0xA0, cause=010, epc=0x40.
- Priority: stage 1 syscall and stage 4 illegal in the same cycle, irq pending → cause=001, epc=exc_pc[4], flush=11111.
- External: irq[2] rises with mask=0100, commit_pc=0x200 → irq_pending=0100, cause=000, epc=0x200, pc_target=0x80; irq_ack=0100 clears it; irq[0] rising in HANDLER is latched but not taken until RETURN.
- Return: eret in HANDLER → one cycle pc_target=epc, pc_redirect=1, flush=all ones; then IDLE, cause=100.
- Nesting: illegal exception in HANDLER with eret in the same cycle → nest_err=1, cause=001, re-flush; no RETURN.
